aes_chain_sequencer: RTL and testbench
======================================

Name: aes_chain_sequencer

Overview:
- Sequences the AES_Composite_enc core through N chained encryptions: C0 = AES(K, P), Ci = AES(K, Ci-1).
- Loads the key once per job.
- Feeds each ciphertext back as the next plaintext.
- Returns the final ciphertext to a host with a start/done handshake.
- A per-wait watchdog flags a stalled core.
- Sits between the host/bus wrapper and the AES core; it replaces manual Krdy/Drdy pulsing.

Parameters:
- ITER_W, 16, width of the iteration count.
- TIMEOUT, 4095, maximum cycles spent in any wait state before ERR.
- TO_W, 12, watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  job request; sampled only in IDLE.
- KEY  in  128  key; captured on accepted START.
- PT  in  128  initial plaintext; captured on accepted START.
- NITER  in  ITER_W  number of encryptions; 0 is treated as 1.
- BUSY  out  1  job in progress.
- DONE  out  1  one-cycle pulse when RESULT is valid.
- ERR  out  1  one-cycle pulse on watchdog expiry.
- RESULT  out  128  final ciphertext; holds until the next DONE.
- ITER_CNT  out  ITER_W  number of encryptions completed in the current job.
- core_RSTn  out  1  core reset; equals ~RST, registered.
- core_EN  out  1  core enable; 1 whenever not IDLE.
- core_Kin  out  128  registered key.
- core_Din  out  128  registered data.
- core_Krdy  out  1  key-load strobe.
- core_Drdy  out  1  data strobe.
- core_Kvld  in  1  key expansion done.
- core_Dvld  in  1  ciphertext valid.
- core_BSY  in  1  core busy.
- core_Dout  in  128  ciphertext.

Behaviour:
- Reset state: state=IDLE; BUSY=0; DONE=0; ERR=0; RESULT=0; ITER_CNT=0; core_Krdy=0; core_Drdy=0; core_EN=0; core_Kin=0; core_Din=0; core_RSTn=0 (for one cycle after RST deasserts, then 1).
- States and transitions:
  - IDLE: on START=1:
    - Latch KEY into core_Kin and PT into core_Din.
    - Latch target = max(NITER, 1).
    - Clear ITER_CNT and the watchdog.
    - Go to KLOAD.
  - KLOAD: assert core_Krdy for exactly one cycle, then go to KWAIT.
  - KWAIT: wait for core_Kvld=1, then go to DLOAD. The watchdog runs.
  - DLOAD:
    - If core_BSY=1, hold; the watchdog runs.
    - Otherwise assert core_Drdy for exactly one cycle, then go to DWAIT.
  - DWAIT: on core_Dvld=1:
    - Capture core_Dout into core_Din and increment ITER_CNT.
    - If ITER_CNT+1 == target: RESULT <= core_Dout, pulse DONE, go to IDLE.
    - Otherwise go to DLOAD.
- BUSY=1 in every state except IDLE. DONE and ERR are asserted in the cycle in which the state returns to IDLE.
- Strobe rules:
  - core_Krdy and core_Drdy are registered and never high in the same cycle.
  - core_Krdy is never high twice per job; the key is loaded exactly once.
- Watchdog:
  - Counter clears on every state change and counts while in KWAIT, DLOAD or DWAIT.
  - When it reaches TIMEOUT: pulse ERR, go to IDLE, leave RESULT unchanged, freeze ITER_CNT.
- Simultaneous events:
  - START while BUSY is ignored, with no queuing.
  - core_Dvld in the same cycle the watchdog hits TIMEOUT: Dvld wins and the watchdog is ignored.
  - core_Dvld or core_Kvld outside its own wait state is ignored.
- Widths and wrap:
  - ITER_CNT counts to target ≤ 2^ITER_W−1 without wrap.
  - NITER is sampled only at START; changes while BUSY have no effect.
- Reset mid-job: RST has priority over everything, aborts any state to IDLE with reset values, and emits no DONE or ERR pulse.
- Latency: START to the first core_Krdy is 1 cycle; core_Dvld to DONE is 1 cycle.

Test Plan:
- Single encryption:
  - Stimulus: RST 2 cycles; START with KEY=0123456789abcdef123456789abcdef0, PT=0, NITER=1.
  - Required: exactly one core_Krdy pulse and one core_Drdy pulse; on Dvld, RESULT equals the core's ciphertext for that key/plaintext; DONE pulses 1 cycle later; BUSY falls with it; ITER_CNT=1.
- Ten chained encryptions:
  - Stimulus: same key, PT=0, NITER=10.
  - Required: 1 Krdy pulse and 10 Drdy pulses; each core_Din after the first equals the previous core_Dout; RESULT matches a software 10-fold chain; ITER_CNT=10.
- NITER=0 → behaves as NITER=1: one Drdy pulse, DONE, ITER_CNT=1.
- START held high through a job → no second job starts until the IDLE cycle after DONE; Krdy count equals the number of completed jobs.
- Watchdog:
  - Stimulus: core model withholds Dvld; TIMEOUT=20.
  - Required: ERR pulses after 20 cycles in DWAIT; BUSY falls; RESULT keeps its prior value; no DONE.
- Reset mid-job:
  - Stimulus: assert RST during the 3rd DWAIT of a NITER=5 job.
  - Required: next cycle all outputs are at reset values; no DONE or ERR; core_RSTn is low for one cycle after RST deasserts; a new START afterwards completes normally.

Source files
------------

// File: rtl/aes_chain_sequencer.sv
// aes_chain_sequencer: drives an AES_Composite_enc core through a chain of
// encryptions C0 = AES(K, P), Ci = AES(K, Ci-1). The key is loaded once per
// job. Each ciphertext is fed back as the next plaintext, and the final
// ciphertext is returned to the host with a start/done handshake. A watchdog
// bounds the time spent waiting on the core in any single wait state.
module aes_chain_sequencer #(
  parameter int ITER_W  = 16,
  parameter int TIMEOUT = 4095,
  parameter int TO_W    = 12
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [127:0]      KEY,
  input  logic [127:0]      PT,
  input  logic [ITER_W-1:0] NITER,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [127:0]      RESULT,
  output logic [ITER_W-1:0] ITER_CNT,
  output logic              core_RSTn,
  output logic              core_EN,
  output logic [127:0]      core_Kin,
  output logic [127:0]      core_Din,
  output logic              core_Krdy,
  output logic              core_Drdy,
  input  logic              core_Kvld,
  input  logic              core_Dvld,
  input  logic              core_BSY,
  input  logic [127:0]      core_Dout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KLOAD = 3'd1,
    S_KWAIT = 3'd2,
    S_DLOAD = 3'd3,
    S_DWAIT = 3'd4
  } state_t;

  state_t            state_reg;
  logic [ITER_W-1:0] target_reg;
  logic [TO_W-1:0]   wd_reg;

  // Incremented watchdog value; expiry is declared when this count of
  // cycles in the current wait state reaches TIMEOUT.
  logic [TO_W-1:0]   wd_next;
  logic              wd_expire;
  logic [ITER_W-1:0] iter_next;
  logic              last_iter;

  assign wd_next   = wd_reg + 1'b1;
  assign wd_expire = (wd_next == TO_W'(TIMEOUT));
  assign iter_next = ITER_CNT + 1'b1;
  assign last_iter = (iter_next == target_reg);

  // Core reset follows the host reset, delayed by one register stage.
  always_ff @(posedge CLK) begin
    core_RSTn <= ~RST;
  end

  // Job sequencer: state, strobes, watchdog, counters and host outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= S_IDLE;
      target_reg <= '0;
      wd_reg     <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      RESULT     <= '0;
      ITER_CNT   <= '0;
      core_EN    <= 1'b0;
      core_Kin   <= '0;
      core_Din   <= '0;
      core_Krdy  <= 1'b0;
      core_Drdy  <= 1'b0;
    end else begin
      // Pulsed outputs default low; they are raised for a single cycle below.
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      core_Krdy <= 1'b0;
      core_Drdy <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (START) begin
            core_Kin   <= KEY;
            core_Din   <= PT;
            // A request for zero encryptions still performs one.
            target_reg <= (NITER == '0) ? ITER_W'(1) : NITER;
            ITER_CNT   <= '0;
            wd_reg     <= '0;
            // Krdy is raised together with the move to KLOAD so it is
            // visible one cycle after START.
            core_Krdy  <= 1'b1;
            BUSY       <= 1'b1;
            core_EN    <= 1'b1;
            state_reg  <= S_KLOAD;
          end
        end

        S_KLOAD: begin
          wd_reg    <= '0;
          state_reg <= S_KWAIT;
        end

        S_KWAIT: begin
          if (core_Kvld) begin
            wd_reg    <= '0;
            state_reg <= S_DLOAD;
          end else if (wd_expire) begin
            wd_reg    <= '0;
            ERR       <= 1'b1;
            BUSY      <= 1'b0;
            core_EN   <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            wd_reg <= wd_next;
          end
        end

        S_DLOAD: begin
          if (!core_BSY) begin
            // Drdy is high during the first DWAIT cycle.
            core_Drdy <= 1'b1;
            wd_reg    <= '0;
            state_reg <= S_DWAIT;
          end else if (wd_expire) begin
            wd_reg    <= '0;
            ERR       <= 1'b1;
            BUSY      <= 1'b0;
            core_EN   <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            wd_reg <= wd_next;
          end
        end

        S_DWAIT: begin
          // A ciphertext arriving on the expiry cycle is still accepted.
          if (core_Dvld) begin
            core_Din <= core_Dout;
            ITER_CNT <= iter_next;
            wd_reg   <= '0;
            if (last_iter) begin
              RESULT    <= core_Dout;
              DONE      <= 1'b1;
              BUSY      <= 1'b0;
              core_EN   <= 1'b0;
              state_reg <= S_IDLE;
            end else begin
              state_reg <= S_DLOAD;
            end
          end else if (wd_expire) begin
            wd_reg    <= '0;
            ERR       <= 1'b1;
            BUSY      <= 1'b0;
            core_EN   <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            wd_reg <= wd_next;
          end
        end

        default: begin
          wd_reg    <= '0;
          BUSY      <= 1'b0;
          core_EN   <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_chain_sequencer.sv
// Directed bench for aes_chain_sequencer. A behavioural stand-in for the AES
// core uses a simple keyed mixing function so chained results can be
// predicted in software.
module tb_aes_chain_sequencer;

  localparam logic [127:0] K0 = 128'h0123456789abcdef123456789abcdef0;
  // cipher(K0, 0) = K0 ^ {16{5a}}, worked out byte by byte.
  localparam logic [127:0] C_SINGLE = 128'h5b791f3dd3f197b5486e0c22c0e684aa;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] pt = '0;
  logic [15:0]  niter = '0;
  logic         busy, done, err;
  logic [127:0] result;
  logic [15:0]  iter_cnt;
  logic         core_rstn, core_en, core_krdy, core_drdy;
  logic [127:0] core_kin, core_din;
  logic         core_kvld = 1'b0;
  logic         core_dvld = 1'b0;
  logic         core_bsy = 1'b0;
  logic [127:0] core_dout = '0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  aes_chain_sequencer #(.ITER_W(16), .TIMEOUT(20), .TO_W(12)) dut (
    .CLK(clk), .RST(rst), .START(start), .KEY(key), .PT(pt), .NITER(niter),
    .BUSY(busy), .DONE(done), .ERR(err), .RESULT(result), .ITER_CNT(iter_cnt),
    .core_RSTn(core_rstn), .core_EN(core_en), .core_Kin(core_kin),
    .core_Din(core_din), .core_Krdy(core_krdy), .core_Drdy(core_drdy),
    .core_Kvld(core_kvld), .core_Dvld(core_dvld), .core_BSY(core_bsy),
    .core_Dout(core_dout)
  );

  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] d);
    return {d[119:0], d[127:120]} ^ k ^ {16{8'h5a}};
  endfunction

  function automatic logic [127:0] chain(input logic [127:0] k, input logic [127:0] p, input int n);
    logic [127:0] d;
    d = p;
    for (int i = 0; i < n; i++) d = cipher(k, d);
    return d;
  endfunction

  // Core stand-in: key ready 3 cycles after Krdy, ciphertext 4 cycles after Drdy.
  logic [127:0] m_key = '0, m_din = '0, last_dout = '0;
  int kdelay = 0, ddelay = 0, job_drdy = 0;
  int krdy_n = 0, drdy_n = 0, done_n = 0, err_n = 0;
  logic chain_bad = 1'b0, both_hi = 1'b0, withhold = 1'b0;

  // Reactive core model and pulse counters.
  always @(posedge clk) begin
    core_kvld <= 1'b0;
    core_dvld <= 1'b0;
    if (core_krdy && core_drdy) both_hi <= 1'b1;
    if (done) done_n <= done_n + 1;
    if (err) err_n <= err_n + 1;
    if (rst) begin
      kdelay   <= 0;
      ddelay   <= 0;
      core_bsy <= 1'b0;
    end else begin
      if (core_krdy) begin
        m_key    <= core_kin;
        kdelay   <= 3;
        krdy_n   <= krdy_n + 1;
        job_drdy <= 0;
      end else if (kdelay == 1) begin
        core_kvld <= 1'b1;
        kdelay    <= 0;
      end else if (kdelay > 1) begin
        kdelay <= kdelay - 1;
      end
      if (core_drdy) begin
        drdy_n   <= drdy_n + 1;
        job_drdy <= job_drdy + 1;
        if (job_drdy > 0 && core_din != last_dout) chain_bad <= 1'b1;
        if (!withhold) begin
          m_din    <= core_din;
          ddelay   <= 4;
          core_bsy <= 1'b1;
        end
      end else if (ddelay == 1) begin
        core_dvld <= 1'b1;
        core_dout <= cipher(m_key, m_din);
        last_dout <= cipher(m_key, m_din);
        core_bsy  <= 1'b0;
        ddelay    <= 0;
      end else if (ddelay > 1) begin
        ddelay <= ddelay - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [127:0] p, input logic [15:0] n);
    key   = K0;
    pt    = p;
    niter = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Waits (bounded) for DONE; returns cycles between the last Dvld and DONE.
  task automatic wait_done(input string tag, output int gap);
    int c;
    int dv;
    dv = -1000;
    for (c = 0; c < 2000; c++) begin
      if (done) break;
      if (core_dvld) dv = c;
      tick();
    end
    check({tag, " done seen"}, done, 1'b1);
    gap = c - dv;
    $display("job %s: result=%h iter_cnt=%0d", tag, result, iter_cnt);
  endtask

  initial begin
    int gap, k_s, d_s, dn_s, er_s, c, dr;
    logic [127:0] exp2;
    exp2 = chain(K0, '0, 2);

    // Reset state
    tick(); tick();
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst err", err, 1'b0);
    check("rst result", result, '0);
    check("rst iter", iter_cnt, '0);
    check("rst strobes", {core_krdy, core_drdy, core_en}, '0);
    check("rst kin", core_kin, '0);
    check("rst din", core_din, '0);
    rst = 1'b0;
    check("rstn low after release", core_rstn, 1'b0);
    tick();
    check("rstn high", core_rstn, 1'b1);

    // Single encryption
    k_s = krdy_n; d_s = drdy_n;
    key = K0; pt = '0; niter = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("krdy latency", core_krdy, 1'b1);
    check("busy on start", busy, 1'b1);
    wait_done("single", gap);
    check("single result", result, C_SINGLE);
    check("single dvld->done", gap, 1);
    check("single busy low", busy, 1'b0);
    check("single iter", iter_cnt, 16'd1);
    check("single krdy count", krdy_n - k_s, 1);
    check("single drdy count", drdy_n - d_s, 1);

    // Ten chained encryptions
    tick();
    k_s = krdy_n; d_s = drdy_n;
    start_job('0, 16'd10);
    wait_done("chain10", gap);
    check("chain10 result", result, chain(K0, '0, 10));
    check("chain10 iter", iter_cnt, 16'd10);
    check("chain10 krdy count", krdy_n - k_s, 1);
    check("chain10 drdy count", drdy_n - d_s, 10);
    check("chain10 din feedback", chain_bad, 1'b0);

    // NITER = 0 behaves as 1
    tick();
    d_s = drdy_n;
    start_job(128'h00112233445566778899aabbccddeeff, 16'd0);
    wait_done("niter0", gap);
    check("niter0 result", result, cipher(K0, 128'h00112233445566778899aabbccddeeff));
    check("niter0 iter", iter_cnt, 16'd1);
    check("niter0 drdy count", drdy_n - d_s, 1);

    // START held high across three jobs
    tick();
    k_s = krdy_n; dn_s = done_n;
    key = K0; pt = '0; niter = 16'd2; start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      wait_done("held", gap);
      if (j == 0) check("held no queued job", krdy_n - k_s, 1);
    end
    start = 1'b0;
    tick(); tick(); tick();
    check("held busy idle", busy, 1'b0);
    check("held krdy count", krdy_n - k_s, 3);
    check("held done count", done_n - dn_s, 3);
    check("held result", result, exp2);

    // Watchdog: core withholds Dvld
    withhold = 1'b1;
    dn_s = done_n; er_s = err_n;
    start_job(128'h1, 16'd1);
    dr = -1000;
    for (c = 0; c < 300; c++) begin
      if (err) break;
      if (core_drdy) dr = c;
      tick();
    end
    check("wd err seen", err, 1'b1);
    check("wd dwait cycles", c - dr, 20);
    check("wd busy low", busy, 1'b0);
    check("wd result kept", result, exp2);
    check("wd iter frozen", iter_cnt, '0);
    tick();
    check("wd no done", done_n - dn_s, 0);
    check("wd one err", err_n - er_s, 1);
    $display("job watchdog: err after %0d cycles", c - dr);
    withhold = 1'b0;

    // Reset during the third DWAIT of a 5-iteration job
    tick();
    d_s = drdy_n; dn_s = done_n; er_s = err_n;
    start_job('0, 16'd5);
    for (c = 0; c < 500; c++) begin
      if (drdy_n - d_s == 3) break;
      tick();
    end
    check("mid reached 3rd dwait", drdy_n - d_s, 3);
    rst = 1'b1;
    tick();
    check("mid busy", busy, 1'b0);
    check("mid result", result, '0);
    check("mid iter", iter_cnt, '0);
    check("mid pulses", {done, err, core_krdy, core_drdy, core_en}, '0);
    check("mid kin din", {core_kin, core_din} == '0, 1'b1);
    rst = 1'b0;
    check("mid rstn low", core_rstn, 1'b0);
    tick();
    check("mid rstn high", core_rstn, 1'b1);
    tick(); tick();
    check("mid no done/err", {done_n - dn_s, err_n - er_s}, '0);
    start_job('0, 16'd2);
    wait_done("after reset", gap);
    check("after reset result", result, exp2);
    check("after reset iter", iter_cnt, 16'd2);

    check("krdy/drdy overlap", both_hi, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
